// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads a synchronous-read instruction RAM
// and hands each word downstream over a valid/ready handshake, with branch redirect.
module instr_fetch #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   instr_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                valid_q;

  // Redirect overrides everything but INIT; in HOLD it also retires the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (state_q == S_INIT) begin
      pc_q    <= start_pc;
      state_q <= S_REQ;
    end else if (redirect) begin
      pc_q    <= redirect_pc;
      valid_q <= 1'b0;
      state_q <= S_REQ;
    end else begin
      case (state_q)
        S_REQ: state_q <= S_CAP;
        S_CAP: begin
          instr_q    <= mem_rdata;
          instr_pc_q <= pc_q;
          valid_q    <= 1'b1;
          pc_q       <= pc_q + ADDR_W'(1);
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized + directed bench for instr_fetch against a countdown-based fetch model
// and a bench-owned synchronous-read RAM.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: next fetch address, edges left until capture, and the word on offer.
  bit                m_first;
  bit                m_valid;
  logic [DATA_W-1:0] m_instr;
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_addr;
  int                m_cnt;
  int                m_hs;
  int                obs_hs;

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pc    (start_pc),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    m_addr  = '0;
    m_cnt   = 0;
  endtask

  // One rising edge: start_pc load, redirect, handshake, or count toward capture.
  task automatic model_step();
    if (m_first) begin
      m_addr  = start_pc;
      m_first = 1'b0;
      m_cnt   = 2;
    end else if (redirect) begin
      if (m_valid && instr_ready) m_hs++;
      m_valid = 1'b0;
      m_addr  = redirect_pc;
      m_cnt   = 2;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_hs++;
        m_valid = 1'b0;
        m_cnt   = 2;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_instr = ram[m_addr];
        m_pc    = m_addr;
        m_addr  = m_addr + 8'd1;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".valid"},    32'(instr_valid), 32'(m_valid));
    check({where, ".instr"},    32'(instr),       32'(m_instr));
    check({where, ".instr_pc"}, 32'(instr_pc),    32'(m_pc));
    check({where, ".mem_addr"}, 32'(mem_addr),    32'(m_addr));
  endtask

  task automatic tick();
    logic pv;
    pv = instr_valid;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (pv && instr_ready) obs_hs++;
      model_step();
    end else begin
      model_reset();
    end
    check_all("tick");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] spc);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    start_pc = spc;
    ticks(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
    ram[8'h05] = 16'hA123;
    ram[8'h06] = 16'h4B07;
    ram[8'h20] = 16'hDEAD;
    ram[8'hFF] = 16'h1111;
    ram[8'h00] = 16'h2222;
    m_hs   = 0;
    obs_hs = 0;
    model_reset();

    // Basic fetch and latency
    instr_ready = 1'b1;
    do_reset(8'h05);
    ticks(3);
    check("basic.instr0",  32'(instr),       32'h0000_A123);
    check("basic.pc0",     32'(instr_pc),    32'h05);
    check("basic.valid0",  32'(instr_valid), 32'h1);
    ticks(3);
    check("basic.instr1",  32'(instr),       32'h0000_4B07);
    check("basic.pc1",     32'(instr_pc),    32'h06);

    // Stall for 5 cycles
    instr_ready = 1'b0;
    ticks(5);
    check("stall.instr",    32'(instr),       32'h0000_4B07);
    check("stall.mem_addr", 32'(mem_addr),    32'h07);
    check("stall.valid",    32'(instr_valid), 32'h1);
    instr_ready = 1'b1;
    tick();
    check("stall.release", 32'(instr_valid), 32'h0);
    ticks(2);
    check("stall.next_pc", 32'(instr_pc),    32'h07);

    // Redirect while in S_CAP
    ticks(2);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    check("redir.drop",  32'(instr_valid), 32'h0);
    tick();
    check("redir.still", 32'(instr_valid), 32'h0);
    tick();
    check("redir.instr", 32'(instr),       32'h0000_DEAD);
    check("redir.pc",    32'(instr_pc),    32'h20);

    // Simultaneous ready and redirect in S_HOLD
    m_hs   = 0;
    obs_hs = 0;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    ticks(2);
    check("both.pc",  32'(instr_pc), 32'h10);
    check("both.hs",  32'(obs_hs),   32'(m_hs));
    check("both.hs1", 32'(obs_hs),   32'h1);

    // PC wrap-around
    do_reset(8'hFF);
    ticks(3);
    check("wrap.instr0", 32'(instr),    32'h0000_1111);
    check("wrap.pc0",    32'(instr_pc), 32'hFF);
    ticks(3);
    check("wrap.instr1", 32'(instr),    32'h0000_2222);
    check("wrap.pc1",    32'(instr_pc), 32'h00);

    // Asynchronous reset mid-cycle while holding a word
    instr_ready = 1'b0;
    tick();
    check("mid.pre_valid", 32'(instr_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.valid",    32'(instr_valid), 32'h0);
    check("mid.mem_addr", 32'(mem_addr),    32'h00);
    check("mid.instr",    32'(instr),       32'h0);
    model_reset();
    start_pc    = 8'h05;
    instr_ready = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    check("mid.restart_pc", 32'(instr_pc), 32'h05);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ADDR_W'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        redirect = 1'b0;
        do_reset(ADDR_W'($urandom));
      end else begin
        tick();
      end
    end
    redirect = 1'b0;
    check("rand.hs", 32'(obs_hs), 32'(m_hs));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the lab7 CPU datapath/controller.
- Owns the program counter and loads it from start_pc after reset.
- Reads 16-bit instruction words from a synchronous-read instruction RAM.
- Hands each word downstream with a valid/ready handshake; a redirect input lets the executing stage steer fetch to a branch target.

Parameters:
- ADDR_W, 8, PC and RAM address width.
- DATA_W, 16, instruction word width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start_pc  input  ADDR_W  initial PC, sampled on the first rising edge after rst_n deasserts.
- mem_addr  output  ADDR_W  RAM read address, always equal to the internal PC register.
- mem_rdata  input  DATA_W  RAM read data, valid in the cycle after the edge that latched mem_addr.
- instr  output  DATA_W  fetched instruction, registered.
- instr_pc  output  ADDR_W  address that instr was fetched from.
- instr_valid  output  1  instr/instr_pc hold a word not yet consumed.
- instr_ready  input  1  downstream accepts the word on this edge.
- redirect  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  branch target.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately when rst_n=0: state=S_INIT, pc=0 (so mem_addr=0), instr=0, instr_pc=0, instr_valid=0.
- State S_INIT: at the next edge, pc<=start_pc and go to S_REQ. redirect is ignored here.
- State S_REQ: mem_addr=pc is presented and the RAM latches it at the edge. Go to S_CAP.
- State S_CAP: mem_rdata is valid. At the edge: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1, go to S_HOLD.
- State S_HOLD: instr_valid=1; instr and instr_pc are held stable for as long as the word waits.
  - At an edge with instr_ready=1: instr_valid<=0 and go to S_REQ.
  - With instr_ready=0: remain in S_HOLD.
- Latency: instr_valid rises after the 3rd edge following reset release. With ready tied high, one instruction per 3 cycles; after a handshake edge, the next valid appears 2 edges later.
- Redirect, in any state except S_INIT: at the edge, pc<=redirect_pc, instr_valid<=0, go to S_REQ.
  - Any in-flight fetch is discarded; the CAP capture does not happen.
  - redirect has priority over instr_ready; when both are 1 the handshake still completes, then the redirect takes effect.
  - First valid from the target appears 2 edges after the redirect edge.
- PC arithmetic is modulo 2^ADDR_W: after fetching address 8'hFF, pc becomes 8'h00 with no flag.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-operation immediately forces the reset values; any pending word is lost. After release, start_pc is re-sampled.
- Downstream sees instr change only on edges where instr_valid goes 0->1.

Test Plan:
- Basic fetch, checks reset load and latency: RAM[5]=16'hA123, RAM[6]=16'h4B07; start_pc=8'h05; reset; ready=1 → after edge 3: instr=16'hA123, instr_pc=8'h05, valid=1; after edge 6: instr=16'h4B07, instr_pc=8'h06.
- Stall: hold ready=0 for 5 cycles while valid=1 → instr, instr_pc and mem_addr unchanged and valid stays 1; raise ready → valid=0 after that edge; next word appears 2 edges later.
- Redirect during S_CAP: redirect=1 with redirect_pc=8'h20 and RAM[20]=16'hDEAD → the pending word is never presented; 2 edges later instr=16'hDEAD, instr_pc=8'h20.
- Simultaneous ready and redirect in S_HOLD: redirect_pc=8'h10 → handshake counted once, and the next instr_pc=8'h10.
- Wrap-around: start_pc=8'hFF, RAM[FF]=16'h1111, RAM[00]=16'h2222 → words appear in order 16'h1111 then 16'h2222 with instr_pc=8'h00.
- Reset mid-stream: assert rst_n=0 mid-cycle while in S_HOLD → valid=0, mem_addr=0 immediately, without waiting for a clock edge; after release with start_pc=8'h05, the first word again has instr_pc=8'h05.
